// File: rtl/aes_ct_serializer_if.sv
// Capture/stream bundle for aes_ct_serializer: ciphertext capture from the round
// controller plus the valid/ready word stream toward the sink.
interface aes_ct_serializer_if #(
    parameter int DATA_W = 128,
    parameter int WORD_W = 32
) ();
    logic [DATA_W-1:0] ct_in;
    logic              eno;
    logic [WORD_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    // master: the environment (controller + sink); slave: the serializer
    modport master (
        output ct_in, eno, out_ready,
        input  out_data, out_valid, out_last
    );

    modport slave (
        input  ct_in, eno, out_ready,
        output out_data, out_valid, out_last
    );
endinterface

// File: rtl/aes_ct_serializer.sv
// AES ciphertext serializer: captures a block on eno, streams it MSW first.
// Define AES_CT_SER_DBUF_EN to add a one-block hold buffer behind the shift register.
//
// state | meaning
// IDLE  | no block in flight, out_valid low
// SEND  | block in shift register, word r_cnt presented
module aes_ct_serializer #(
    parameter int DATA_W = 128,
    parameter int WORD_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    aes_ct_serializer_if.slave   bus,
    input  logic                 i_ovf_clr,
    output logic                 o_busy,
    output logic                 o_ovf
);
    localparam int NWORDS = DATA_W / WORD_W;
    localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t             r_state;
    logic [DATA_W-1:0]  r_shift;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_valid;
    logic               r_last;
    logic               r_ovf;
`ifdef AES_CT_SER_DBUF_EN
    logic [DATA_W-1:0]  r_hold;
    logic               r_hold_full;
`endif

    wire logic w_xfer      = r_valid & bus.out_ready;
    wire logic w_at_last   = (r_cnt == CNT_W'(NWORDS - 1));
    wire logic w_last_xfer = w_xfer & w_at_last;

    // A block arriving on the final transfer is always taken; otherwise it needs free storage.
`ifdef AES_CT_SER_DBUF_EN
    wire logic w_drop = bus.eno & r_hold_full & ~w_last_xfer;
`else
    wire logic w_drop = bus.eno & (r_state == SEND) & ~w_last_xfer;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_ovf       <= 1'b0;
`ifdef AES_CT_SER_DBUF_EN
            r_hold      <= '0;
            r_hold_full <= 1'b0;
`endif
        end else begin
            if (w_drop)
                r_ovf <= 1'b1;
            else if (i_ovf_clr)
                r_ovf <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (bus.eno) begin
                        r_shift <= bus.ct_in;
                        r_cnt   <= '0;
                        r_valid <= 1'b1;
                        r_last  <= (NWORDS == 1);
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    if (w_last_xfer) begin
`ifdef AES_CT_SER_DBUF_EN
                        if (r_hold_full) begin
                            r_shift <= r_hold;
                            r_cnt   <= '0;
                            r_last  <= (NWORDS == 1);
                            if (bus.eno)
                                r_hold <= bus.ct_in;
                            else
                                r_hold_full <= 1'b0;
                        end else if (bus.eno) begin
`else
                        if (bus.eno) begin
`endif
                            r_shift <= bus.ct_in;
                            r_cnt   <= '0;
                            r_last  <= (NWORDS == 1);
                        end else begin
                            r_shift <= '0;
                            r_cnt   <= '0;
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end else begin
                        if (w_xfer) begin
                            r_shift <= r_shift << WORD_W;
                            r_cnt   <= r_cnt + CNT_W'(1);
                            r_last  <= (r_cnt == CNT_W'(NWORDS - 2));
                        end
`ifdef AES_CT_SER_DBUF_EN
                        if (bus.eno && !r_hold_full) begin
                            r_hold      <= bus.ct_in;
                            r_hold_full <= 1'b1;
                        end
`endif
                    end
                end
            endcase
        end
    end

    assign bus.out_data  = r_shift[DATA_W-1 -: WORD_W];
    assign bus.out_valid = r_valid;
    assign bus.out_last  = r_last;
    assign o_ovf         = r_ovf;
`ifdef AES_CT_SER_DBUF_EN
    assign o_busy        = r_hold_full;
`else
    assign o_busy        = (r_state == SEND);
`endif
endmodule
